// File: rtl/tick_generator.sv
// Timebase divider: one-cycle tick every PERIOD (or TPERIOD in turbo) enabled cycles, plus a
// 50% phase square wave. Define TICK_GEN_COUNTDOWN_EN to build the remaining/done countdown.
module tick_generator #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 1,
  parameter int TURBO_DIV = 10,
  parameter int LIMIT     = 90,
  parameter int LIM_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             turbo,
  input  logic             restart,
  output logic             tick,
  output logic             phase,
  output logic [LIM_W-1:0] remaining,
  output logic             done
);

  localparam int PERIOD  = CLK_HZ / TICK_HZ;
  localparam int TPERIOD = PERIOD / TURBO_DIV;
  localparam int CNT_W   = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TPERIOD - 1);
  localparam logic [CNT_W-1:0] P_HALF = CNT_W'(PERIOD / 2);
  localparam logic [CNT_W-1:0] T_HALF = CNT_W'(TPERIOD / 2);

  logic [CNT_W-1:0] cnt, cntNext, lastCnt, halfCnt;
  logic             wrap, frozen;

  assign lastCnt = turbo ? T_LAST : P_LAST;
  assign halfCnt = turbo ? T_HALF : P_HALF;
  // >= so a turbo switch with cnt already past the short period wraps immediately
  assign wrap    = cnt >= lastCnt;
  assign cntNext = cnt + CNT_W'(1);

`ifdef TICK_GEN_COUNTDOWN_EN
  logic [LIM_W-1:0] remReg;
  logic             doneReg;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      remReg  <= LIM_W'(LIMIT);
      doneReg <= 1'b0;
    end else if (!doneReg && enable && wrap && remReg != '0) begin
      remReg <= remReg - LIM_W'(1);
      if (remReg == LIM_W'(1)) doneReg <= 1'b1;
    end
  end

  assign remaining = remReg;
  assign done      = doneReg;
  assign frozen    = doneReg;
`else
  assign remaining = '0;
  assign done      = 1'b0;
  assign frozen    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt   <= '0;
      tick  <= 1'b0;
      phase <= 1'b0;
    end else if (frozen) begin
      cnt   <= '0;
      tick  <= 1'b0;
      phase <= 1'b0;
    end else if (!enable) begin
      tick <= 1'b0;
    end else if (wrap) begin
      cnt   <= '0;
      tick  <= 1'b1;
      phase <= 1'b0;
    end else begin
      cnt  <= cntNext;
      tick <= 1'b0;
      if (cntNext == halfCnt) phase <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tick_generator.sv
// Directed scenarios plus a randomized run, each cycle checked against an integer reference model.
module tb_tick_generator;

  localparam int P_NORM = 20;
  localparam int P_TURB = 5;
  localparam int LIM    = 3;
`ifdef TICK_GEN_COUNTDOWN_EN
  localparam bit CD = 1'b1;
`else
  localparam bit CD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, enable, turbo, restart;
  logic       tick, phase, done;
  logic [7:0] remaining;

  tick_generator #(.CLK_HZ(20), .TICK_HZ(1), .TURBO_DIV(4), .LIMIT(LIM), .LIM_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .turbo(turbo), .restart(restart),
    .tick(tick), .phase(phase), .remaining(remaining), .done(done)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int edgeCnt = 0;
  int tickAt[$];

  // reference model state: enabled edges into the current period, phase flag, countdown
  int mPos = 0, mRem = 0;
  bit mTick = 0, mPh = 0, mDone = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edgeCnt);
    end
  endtask

  function automatic int tickNth(input int i);
    return (i < tickAt.size()) ? tickAt[i] : -1;
  endfunction

  task automatic modelEdge(input bit rst, input bit rs, input bit en, input bit tb);
    int p;
    p = tb ? P_TURB : P_NORM;
    if (rst || rs) begin
      mPos = 0; mTick = 0; mPh = 0; mRem = CD ? LIM : 0; mDone = 0;
    end else if (mDone) begin
      mPos = 0; mTick = 0; mPh = 0;
    end else if (!en) begin
      mTick = 0;
    end else if (mPos + 1 >= p) begin
      mPos = 0; mTick = 1; mPh = 0;
      if (CD && mRem > 0) begin
        mRem--;
        if (mRem == 0) mDone = 1;
      end
    end else begin
      mPos++; mTick = 0;
      if (mPos == p / 2) mPh = 1;
    end
  endtask

  task automatic step(input bit rst, input bit rs, input bit en, input bit tb);
    reset = rst; restart = rs; enable = en; turbo = tb;
    @(posedge clk);
    modelEdge(rst, rs, en, tb);
    #1;
    edgeCnt++;
    if (tick === 1'b1) tickAt.push_back(edgeCnt);
    chk("tick", int'(tick), int'(mTick));
    chk("phase", int'(phase), int'(mPh));
    chk("remaining", int'(remaining), mRem);
    chk("done", int'(done), int'(mDone));
  endtask

  task automatic mark();
    edgeCnt = 0;
    tickAt.delete();
  endtask

  task automatic run(input int n, input bit en, input bit tb);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, en, tb);
  endtask

  initial begin
    reset = 1'b1; restart = 1'b0; enable = 1'b0; turbo = 1'b0;

    // reset state
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rstTick", int'(tick), 0);
    chk("rstPhase", int'(phase), 0);
    chk("rstRemaining", int'(remaining), CD ? LIM : 0);
    chk("rstDone", int'(done), 0);

    // free run: ticks at 20/40/60, phase high over the second half of each period
    mark();
    for (int n = 1; n <= 60; n++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("freeTick", int'(tick), int'(n % 20 == 0));
      chk("freePhase", int'(phase), int'(n % 20 >= 10));
    end
    chk("freeCount", tickAt.size(), 3);

    // pause 7 cycles at cnt=8
    step(1'b0, 1'b1, 1'b1, 1'b0);
    mark();
    run(8, 1'b1, 1'b0);
    run(7, 1'b0, 1'b0);
    run(15, 1'b1, 1'b0);
    chk("pauseTick", tickNth(0), 27);

    // turbo on at cnt=12: immediate wrap, then every 5
    step(1'b0, 1'b1, 1'b1, 1'b0);
    mark();
    run(12, 1'b1, 1'b0);
    run(7, 1'b1, 1'b1);
    chk("turboOnTick0", tickNth(0), 13);
    chk("turboOnTick1", tickNth(1), 18);

    // turbo off at cnt=3: wrap 17 edges later
    step(1'b0, 1'b1, 1'b1, 1'b0);
    mark();
    run(8, 1'b1, 1'b1);
    run(20, 1'b1, 1'b0);
    chk("turboOffTick0", tickNth(0), 5);
    chk("turboOffTick1", tickNth(1), 25);

    // restart colliding with a wrap
    step(1'b0, 1'b1, 1'b1, 1'b0);
    run(19, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("collideTick", int'(tick), 0);
    mark();
    run(20, 1'b1, 1'b0);
    chk("collideNext", tickNth(0), 20);

    // reset mid-period
    run(7, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    mark();
    run(20, 1'b1, 1'b0);
    chk("midResetNext", tickNth(0), 20);

    // countdown stimulus: 3 periods then 100 more cycles
    step(1'b0, 1'b1, 1'b1, 1'b0);
    mark();
    run(160, 1'b1, 1'b0);
    chk("cdTickCount", tickAt.size(), CD ? 3 : 8);
    chk("cdLastTick", tickNth(2), 60);
    chk("cdDone", int'(done), CD ? 1 : 0);
    chk("cdRemaining", int'(remaining), 0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("cdRestartRem", int'(remaining), CD ? LIM : 0);
    chk("cdRestartDone", int'(done), 0);

    // randomized control
    begin
      bit tb = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(99) < 5) tb = ~tb;
        step($urandom_range(199) == 0, $urandom_range(99) == 0, $urandom_range(99) < 85, tb);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
